// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper for the
// character LCD writers.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_PASS        = 8'h50;
  localparam logic [7:0] ASCII_FAIL        = 8'h46;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE
  } lcd_state_e;

  // 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_hex_writer_if.sv
// Request/status handshake plus the HD44780 8-bit write bus.
interface lcd_hex_writer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [6:0]        addr;
  logic [DATA_W-1:0] value;
  logic              status;
  logic              busy;
  logic              done;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              lcd_en;
  logic [7:0]        lcd_data;

  modport master (
    output start, addr, value, status,
    input  busy, done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport slave (
    input  start, addr, value, status,
    output busy, done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/lcd_hex_ascii.sv
// Combinational 4-bit nibble to uppercase hex ASCII character.
module lcd_hex_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);
  assign ascii_o = nib2ascii(nib_i);
endmodule

// File: rtl/lcd_hex_writer.sv
// Prints a captured value as hex on an HD44780 LCD: DDRAM address command,
// hex digits, optional " P"/" F" suffix, each byte with setup/enable/settle timing.
module lcd_hex_writer
  import lcd_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit SUFFIX_EN    = 1'b1,
  parameter int SETUP_CYC    = 4,
  parameter int EN_PULSE_CYC = 24,
  parameter int SETTLE_CYC   = 2000
) (
  input logic           clk,
  input logic           rst_n,
  lcd_hex_writer_if.slave bus
);
  localparam int DIGITS  = DATA_W / 4;
  localparam int N       = 1 + DIGITS + (SUFFIX_EN ? 2 : 0);
  localparam int IDX_W   = $clog2(N);
  localparam int MAX_A   = (SETUP_CYC > EN_PULSE_CYC) ? SETUP_CYC : EN_PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  if (DATA_W % 4 != 0 || DATA_W < 4 || DATA_W > 64) begin : g_bad_width
    $error("lcd_hex_writer: DATA_W must be a multiple of 4 in 4..64");
  end
  if (SETUP_CYC < 1 || EN_PULSE_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_cyc
    $error("lcd_hex_writer: all *_CYC parameters must be >= 1");
  end

  lcd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              status_q, status_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              en_q, busy_q, done_q, done_d;
  logic              load_byte;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    value_d   = value_q;
    status_d  = status_q;
    done_d    = 1'b0;
    load_byte = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        addr_d    = bus.addr;
        value_d   = bus.value;
        status_d  = bus.status;
        idx_d     = '0;
        state_d   = ST_SETUP;
        cnt_d     = SETUP_LD;
        load_byte = 1'b1;
      end
      ST_SETUP: if (cnt_q == '0) begin
        state_d = ST_PULSE;
        cnt_d   = PULSE_LD;
      end else cnt_d = cnt_q - 1'b1;
      ST_PULSE: if (cnt_q == '0) begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LD;
      end else cnt_d = cnt_q - 1'b1;
      ST_SETTLE: if (cnt_q == '0) begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d     = idx_q + 1'b1;
          state_d   = ST_SETUP;
          cnt_d     = SETUP_LD;
          load_byte = 1'b1;
        end
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte content is chosen from the next-state index so it is registered
  // onto the bus on the same edge that enters SETUP.
  logic [IDX_W-1:0] nib_sel;
  logic [3:0]       nib;
  logic [7:0]       digit_ascii;

  always_comb begin
    nib_sel = MSB_FIRST ? (IDX_W'(DIGITS) - idx_d) : (idx_d - IDX_W'(1));
    nib     = 4'(value_d >> {nib_sel, 2'b00});
  end

  lcd_hex_ascii u_hex (.nib_i(nib), .ascii_o(digit_ascii));

  always_comb begin
    rs_d   = rs_q;
    data_d = data_q;
    if (load_byte) begin
      if (idx_d == '0) begin
        rs_d   = 1'b0;
        data_d = LCD_CMD_SET_DDRAM | {1'b0, addr_d};
      end else begin
        rs_d = 1'b1;
        if (idx_d <= IDX_W'(DIGITS))        data_d = digit_ascii;
        else if (idx_d == IDX_W'(DIGITS+1)) data_d = ASCII_SPACE;
        else                                data_d = status_d ? ASCII_FAIL : ASCII_PASS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      value_q  <= '0;
      status_q <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
      status_q <= status_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      en_q     <= (state_d == ST_PULSE);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  end

  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_data = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer: a 32-bit MSB-first instance with suffix and an
// 8-bit LSB-first instance without suffix, checked against a byte-list model.
module tb_lcd_hex_writer;
  localparam int SETUP  = 2;
  localparam int PULSE  = 3;
  localparam int SETTLE = 5;
  localparam int T      = SETUP + PULSE + SETTLE;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_hex_writer_if #(.DATA_W(32)) b0 ();
  lcd_hex_writer_if #(.DATA_W(8))  b1 ();

  lcd_hex_writer #(.DATA_W(32), .MSB_FIRST(1'b1), .SUFFIX_EN(1'b1),
    .SETUP_CYC(SETUP), .EN_PULSE_CYC(PULSE), .SETTLE_CYC(SETTLE))
    u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  lcd_hex_writer #(.DATA_W(8), .MSB_FIRST(1'b0), .SUFFIX_EN(1'b0),
    .SETUP_CYC(SETUP), .EN_PULSE_CYC(PULSE), .SETTLE_CYC(SETTLE))
    u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b[$];
  bit         exp_rs[$];
  logic [7:0] obs_b[$];
  bit         obs_rs[$];
  int         rise_rel[$];
  int         width_q[$];
  int         done_rel, busy_bad, stab_bad;
  bit         busy_at_done;

  // Expected byte stream built straight from the display rules.
  function automatic void model(input int dw, input bit msb, input bit sfx,
                                input logic [6:0] a, input logic [63:0] v, input bit st);
    exp_b.delete();
    exp_rs.delete();
    exp_b.push_back(8'h80 + {1'b0, a});
    exp_rs.push_back(1'b0);
    for (int k = 0; k < dw / 4; k++) begin
      int pos = msb ? (dw / 4 - 1 - k) : k;
      int n   = int'((v >> (4 * pos)) & 64'hF);
      exp_b.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
      exp_rs.push_back(1'b1);
    end
    if (sfx) begin
      exp_b.push_back(8'h20);
      exp_rs.push_back(1'b1);
      exp_b.push_back(st ? 8'h46 : 8'h50);
      exp_rs.push_back(1'b1);
    end
  endfunction

  task automatic drive(input bit sel, input bit s, input logic [6:0] a,
                       input logic [63:0] v, input bit st);
    if (sel) begin
      b1.start = s; b1.addr = a; b1.value = v[7:0]; b1.status = st;
    end else begin
      b0.start = s; b0.addr = a; b0.value = v[31:0]; b0.status = st;
    end
  endtask

  // Called at a negedge: raises Start for the coming edge, then watches the bus
  // until Done (returns at the negedge of the Done cycle) or the budget expires.
  task automatic run(input bit sel, input logic [6:0] a, input logic [63:0] v,
                     input bit st, input int glitch_rel);
    bit prev_en = 1'b0;
    int w = 0;
    logic [7:0] held_d = 8'h00;
    bit held_rs = 1'b0;
    obs_b.delete(); obs_rs.delete(); rise_rel.delete(); width_q.delete();
    done_rel = -1; busy_bad = 0; stab_bad = 0; busy_at_done = 1'b1;
    drive(sel, 1'b1, a, v, st);
    for (int rel = 1; rel <= 400; rel++) begin
      bit en, rs, busy, done;
      logic [7:0] d;
      @(negedge clk);
      if (rel == 1 || (glitch_rel > 0 && rel == glitch_rel + 1))
        drive(sel, 1'b0, 7'($urandom), {$urandom, $urandom}, 1'($urandom));
      if (glitch_rel > 0 && rel == glitch_rel)
        drive(sel, 1'b1, 7'($urandom), {$urandom, $urandom}, 1'($urandom));
      en   = sel ? b1.lcd_en   : b0.lcd_en;
      rs   = sel ? b1.lcd_rs   : b0.lcd_rs;
      d    = sel ? b1.lcd_data : b0.lcd_data;
      busy = sel ? b1.busy     : b0.busy;
      done = sel ? b1.done     : b0.done;
      if (done) begin
        done_rel = rel;
        busy_at_done = busy;
        break;
      end
      if (!busy) busy_bad++;
      if (en && !prev_en) begin
        obs_b.push_back(d); obs_rs.push_back(rs); rise_rel.push_back(rel);
        held_d = d; held_rs = rs;
      end
      if (en) begin
        w++;
        if (d !== held_d || rs !== held_rs) stab_bad++;
      end else if (prev_en) begin
        width_q.push_back(w);
        w = 0;
      end
      prev_en = en;
    end
  endtask

  task automatic test_sequence(input string name, input bit sel, input logic [6:0] a,
                               input logic [63:0] v, input bit st, input int glitch_rel);
    int n;
    if (sel) model(8, 1'b0, 1'b0, a, v, st);
    else     model(32, 1'b1, 1'b1, a, v, st);
    run(sel, a, v, st, glitch_rel);
    n = exp_b.size();
    checks++;
    if (obs_b.size() !== n) begin
      errors++;
      $display("FAIL %s byte_count got %0d want %0d", name, obs_b.size(), n);
    end
    for (int i = 0; i < n && i < obs_b.size(); i++) begin
      checks++;
      if (obs_b[i] !== exp_b[i] || obs_rs[i] !== exp_rs[i]) begin
        errors++;
        $display("FAIL %s byte[%0d] got %h/rs%0d want %h/rs%0d", name, i,
                 obs_b[i], obs_rs[i], exp_b[i], exp_rs[i]);
      end
      checks++;
      if (rise_rel[i] !== 1 + i * T + SETUP) begin
        errors++;
        $display("FAIL %s en_rise[%0d] got %0d want %0d", name, i, rise_rel[i], 1 + i * T + SETUP);
      end
    end
    for (int i = 0; i < width_q.size(); i++) begin
      checks++;
      if (width_q[i] !== PULSE) begin
        errors++;
        $display("FAIL %s en_width[%0d] got %0d want %0d", name, i, width_q[i], PULSE);
      end
    end
    checks++;
    if (done_rel !== 1 + n * T) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want %0d", name, done_rel, 1 + n * T);
    end
    checks++;
    if (busy_at_done !== 1'b0 || busy_bad !== 0 || stab_bad !== 0) begin
      errors++;
      $display("FAIL %s busy/stability got busy_at_done=%0d busy_low=%0d unstable=%0d want 0/0/0",
               name, busy_at_done, busy_bad, stab_bad);
    end
  endtask

  task automatic test_reset();
    int en_hi = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b0.lcd_en, b0.lcd_rs, b0.lcd_rw, b0.busy, b0.done} !== 5'b0 || b0.lcd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut32 got en%0d rs%0d rw%0d busy%0d done%0d data%h want all 0",
               b0.lcd_en, b0.lcd_rs, b0.lcd_rw, b0.busy, b0.done, b0.lcd_data);
    end
    checks++;
    if ({b1.lcd_en, b1.lcd_rs, b1.lcd_rw, b1.busy, b1.done} !== 5'b0 || b1.lcd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut8 got en%0d rs%0d rw%0d busy%0d done%0d data%h want all 0",
               b1.lcd_en, b1.lcd_rs, b1.lcd_rw, b1.busy, b1.done, b1.lcd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (b0.lcd_en || b1.lcd_en || b0.busy || b1.busy) en_hi++;
    end
    checks++;
    if (en_hi !== 0) begin
      errors++;
      $display("FAIL idle_after_reset got %0d active cycles want 0", en_hi);
    end
  endtask

  task automatic test_directed();
    repeat (3) @(negedge clk);
    test_sequence("hex_1234ABCD", 1'b0, 7'h40, 64'h1234ABCD, 1'b0, 0);
    repeat (3) @(negedge clk);
    test_sequence("zero_fail", 1'b0, 7'h00, 64'h0, 1'b1, 0);
    repeat (3) @(negedge clk);
    test_sequence("all_F", 1'b0, 7'h7F, 64'hFFFFFFFF, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      repeat (1 + $urandom_range(0, 4)) @(negedge clk);
      test_sequence("random32", 1'b0, 7'($urandom), {32'h0, $urandom}, 1'($urandom), 0);
    end
  endtask

  task automatic test_start_while_busy();
    repeat (3) @(negedge clk);
    test_sequence("start_while_busy", 1'b0, 7'h15, 64'h0F1E2D3C, 1'b1, 37);
  endtask

  task automatic test_back_to_back();
    repeat (3) @(negedge clk);
    test_sequence("b2b_first", 1'b0, 7'h02, 64'h89ABCDEF, 1'b0, 0);
    test_sequence("b2b_second", 1'b0, 7'h41, 64'h01234567, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b1, 7'h10, 64'hCAFEF00D, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h00, 64'h0, 1'b0);
    repeat (43) @(negedge clk);  // rel 44: middle of byte 4 enable pulse
    checks++;
    if (b0.lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse_en got %0d want 1", b0.lcd_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (b0.lcd_en !== 1'b0 || b0.busy !== 1'b0 || b0.lcd_rs !== 1'b0 || b0.lcd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got en%0d busy%0d rs%0d data%h want 0 0 0 00",
               b0.lcd_en, b0.busy, b0.lcd_rs, b0.lcd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_sequence("after_reset", 1'b0, 7'h33, 64'hDEADBEEF, 1'b1, 0);
  endtask

  task automatic test_narrow();
    repeat (3) @(negedge clk);
    test_sequence("w8_5A", 1'b1, 7'h00, 64'h5A, 1'b0, 0);
    repeat (3) @(negedge clk);
    test_sequence("w8_random", 1'b1, 7'($urandom), {56'h0, 8'($urandom)}, 1'($urandom), 0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 7'h0, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 7'h0, 64'h0, 1'b0);
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
